// File: rtl/score_pkg.sv
// Shared types and constants for the score playback sequencer.
package score_pkg;

  localparam int unsigned ADDR_W_DEF   = 5;
  localparam int unsigned NOTE_W_DEF   = 4;
  localparam int unsigned LEN_W_DEF    = 3;
  localparam int unsigned TICK_DIV_DEF = 12_500_000;

  // A stored length of zero terminates a score.
  localparam int unsigned END_MARKER_LEN = 0;
  // Note code presented whenever nothing is sounding.
  localparam int unsigned NOTE_REST      = 0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_LOAD   = 3'd2,
    ST_PLAY   = 3'd3,
    ST_FINISH = 3'd4,
    ST_HALT   = 3'd5
  } score_seq_state_t;

endpackage

// File: rtl/tick_timer.sv
// Length-tick prescaler: one-cycle tick every TICK_DIV cycles while clr_i is low.
// The tick is registered, so it lines up with the last cycle of each TICK_DIV
// window counted from the first cycle after clr_i drops (needs TICK_DIV >= 2).
module tick_timer #(
  parameter int unsigned TICK_DIV = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr_i,
  output logic tick_o
);

  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(TICK_DIV - 2);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  // Next count wraps at TICK_DIV-1; tick is pre-decoded one cycle early.
  always_comb begin
    cnt_d  = cnt_q + CNT_W'(1);
    tick_d = 1'b0;
    if (clr_i) begin
      cnt_d = '0;
    end else begin
      if (cnt_q == CNT_LAST) begin
        cnt_d = '0;
      end
      tick_d = (cnt_q == CNT_PRE);
    end
  end

  // Counter and tick registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/score_sequencer.sv
// Score playback sequencer: walks the random or saved score memory, holds each
// note for its stored length in ticks and pulses done when the score ends.
// Optional build macro SCORE_SEQ_GAP_EN: the final tick of every note is silent.
module score_sequencer
  import score_pkg::*;
#(
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned NOTE_W   = NOTE_W_DEF,
  parameter int unsigned LEN_W    = LEN_W_DEF,
  parameter int unsigned TICK_DIV = TICK_DIV_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              init,
  input  logic              start_rand,
  input  logic              start_save,
  input  logic              end_early,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_sel,
  input  logic [NOTE_W-1:0] rd_note,
  input  logic [LEN_W-1:0]  rd_len,
  output logic [NOTE_W-1:0] note_out,
  output logic              note_valid,
  output logic              done_rand,
  output logic              done_save
);

  localparam logic [ADDR_W-1:0] ADDR_MAX  = {ADDR_W{1'b1}};
  localparam logic [LEN_W-1:0]  LEN_END   = LEN_W'(END_MARKER_LEN);
  localparam logic [LEN_W-1:0]  LEN_ONE   = LEN_W'(1);
  localparam logic [NOTE_W-1:0] NOTE_ZERO = NOTE_W'(NOTE_REST);

  score_seq_state_t  state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              sel_q, sel_d;
  logic [NOTE_W-1:0] cap_note_q, cap_note_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [NOTE_W-1:0] note_out_q, note_out_d;
  logic              note_valid_q, note_valid_d;
  logic              done_rand_q, done_rand_d;
  logic              done_save_q, done_save_d;
  logic              tick;
  logic              timer_clr_c;
  logic              playing_c;

  // Tick timer runs only while a note is being played.
  assign timer_clr_c = init || (state_q != ST_PLAY);

  tick_timer #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clr_i   (timer_clr_c),
    .tick_o  (tick)
  );

  assign playing_c = (state_q == ST_FETCH) || (state_q == ST_LOAD) || (state_q == ST_PLAY);

  // Next-state and registered-output decode.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    sel_d        = sel_q;
    cap_note_d   = cap_note_q;
    len_d        = len_q;
    note_valid_d = 1'b0;
    note_out_d   = NOTE_ZERO;
    done_rand_d  = 1'b0;
    done_save_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_rand) begin
          state_d = ST_FETCH;
          sel_d   = 1'b0;
          addr_d  = '0;
        end else if (start_save) begin
          state_d = ST_FETCH;
          sel_d   = 1'b1;
          addr_d  = '0;
        end
      end
      ST_FETCH: begin
        state_d = ST_LOAD;
      end
      ST_LOAD: begin
        cap_note_d = rd_note;
        len_d      = rd_len;
        if (rd_len == LEN_END) begin
          state_d = ST_FINISH;
        end else begin
          state_d = ST_PLAY;
        end
      end
      ST_PLAY: begin
        if (tick) begin
          if (len_q == LEN_ONE) begin
            if (addr_q == ADDR_MAX) begin
              state_d = ST_FINISH;
            end else begin
              state_d = ST_FETCH;
              addr_d  = addr_q + ADDR_W'(1);
            end
          end else begin
            len_d = len_q - LEN_ONE;
          end
        end
      end
      ST_FINISH: begin
        state_d = ST_HALT;
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Abort: explicit end_early or both start levels released mid-score.
    if (playing_c && (end_early || !(start_rand || start_save))) begin
      state_d = ST_IDLE;
    end

    if (init) begin
      state_d = ST_IDLE;
    end

    // Address and memory select read as zero whenever no score is in progress.
    if ((state_d == ST_IDLE) || (state_d == ST_HALT)) begin
      addr_d = '0;
      sel_d  = 1'b0;
    end

`ifdef SCORE_SEQ_GAP_EN
    note_valid_d = (state_d == ST_PLAY) && (len_d != LEN_ONE);
`else
    note_valid_d = (state_d == ST_PLAY);
`endif
    note_out_d  = note_valid_d ? cap_note_d : NOTE_ZERO;
    done_rand_d = (state_d == ST_FINISH) && !sel_q;
    done_save_d = (state_d == ST_FINISH) &&  sel_q;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      sel_q        <= 1'b0;
      cap_note_q   <= '0;
      len_q        <= '0;
      note_out_q   <= '0;
      note_valid_q <= 1'b0;
      done_rand_q  <= 1'b0;
      done_save_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      sel_q        <= sel_d;
      cap_note_q   <= cap_note_d;
      len_q        <= len_d;
      note_out_q   <= note_out_d;
      note_valid_q <= note_valid_d;
      done_rand_q  <= done_rand_d;
      done_save_q  <= done_save_d;
    end
  end

  assign rd_addr    = addr_q;
  assign rd_sel     = sel_q;
  assign note_out   = note_out_q;
  assign note_valid = note_valid_q;
  assign done_rand  = done_rand_q;
  assign done_save  = done_save_q;

endmodule

// File: tb/tb_score_sequencer.sv
// Directed, table-driven bench for score_sequencer with TICK_DIV=4 and a
// behavioural two-bank score memory with one cycle of read latency.
module tb_score_sequencer;

  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned NOTE_W   = 4;
  localparam int unsigned LEN_W    = 3;
  localparam int unsigned TICK_DIV = 4;
`ifdef SCORE_SEQ_GAP_EN
  localparam bit GAP = 1'b1;
`else
  localparam bit GAP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset_n;
  logic              init, start_rand, start_save, end_early;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_sel;
  logic [NOTE_W-1:0] rd_note;
  logic [LEN_W-1:0]  rd_len;
  logic [NOTE_W-1:0] note_out;
  logic              note_valid, done_rand, done_save;

  logic [NOTE_W-1:0] mem_note [2][32];
  logic [LEN_W-1:0]  mem_len  [2][32];

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic       sr, ss, ee, it;
    logic [4:0] addr;
    logic       sel, nv;
    logic [3:0] note;
    logic       lt, dr, ds;
  } vec_t;

  vec_t tv[$];

  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    rd_note <= mem_note[rd_sel][rd_addr];
    rd_len  <= mem_len[rd_sel][rd_addr];
  end

  score_sequencer #(
    .ADDR_W   (ADDR_W),
    .NOTE_W   (NOTE_W),
    .LEN_W    (LEN_W),
    .TICK_DIV (TICK_DIV)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .init       (init),
    .start_rand (start_rand),
    .start_save (start_save),
    .end_early  (end_early),
    .rd_addr    (rd_addr),
    .rd_sel     (rd_sel),
    .rd_note    (rd_note),
    .rd_len     (rd_len),
    .note_out   (note_out),
    .note_valid (note_valid),
    .done_rand  (done_rand),
    .done_save  (done_save)
  );

  function automatic vec_t mk(logic sr, logic ss, logic ee, logic it, logic [4:0] addr,
                              logic sel, logic nv, logic [3:0] note, logic lt,
                              logic dr, logic ds);
    vec_t v;
    v.sr = sr; v.ss = ss; v.ee = ee; v.it = it;
    v.addr = addr; v.sel = sel; v.nv = nv; v.note = note;
    v.lt = lt; v.dr = dr; v.ds = ds;
    return v;
  endfunction

  // Row that expects every output at zero (IDLE or HALT).
  task automatic add_idle(input logic sr, input logic ss, input logic ee, input logic it);
    tv.push_back(mk(sr, ss, ee, it, 5'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0));
  endtask

  // FETCH + LOAD rows followed by n_play PLAY rows of a note of length len.
  task automatic add_note(input logic sr, input logic ss, input int addr, input logic sel,
                          input logic [3:0] note, input int len, input int n_play);
    tv.push_back(mk(sr, ss, 1'b0, 1'b0, 5'(addr), sel, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0));
    tv.push_back(mk(sr, ss, 1'b0, 1'b0, 5'(addr), sel, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0));
    for (int j = 0; j < n_play; j++) begin
      tv.push_back(mk(sr, ss, 1'b0, 1'b0, 5'(addr), sel, 1'b1, note,
                      (j >= (len - 1) * int'(TICK_DIV)), 1'b0, 1'b0));
    end
  endtask

  // FINISH row with the done pulse, then a HALT row.
  task automatic add_finish(input logic sr, input logic ss, input int addr, input logic sel);
    tv.push_back(mk(sr, ss, 1'b0, 1'b0, 5'(addr), sel, 1'b0, 4'd0, 1'b0, ~sel, sel));
    add_idle(sr, ss, 1'b0, 1'b0);
  endtask

  // End-marker fetch: FETCH, LOAD, FINISH, HALT.
  task automatic add_end(input logic sr, input logic ss, input int addr, input logic sel);
    tv.push_back(mk(sr, ss, 1'b0, 1'b0, 5'(addr), sel, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0));
    tv.push_back(mk(sr, ss, 1'b0, 1'b0, 5'(addr), sel, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0));
    add_finish(sr, ss, addr, sel);
  endtask

  task automatic check_zero(input string name);
    checks++;
    if ({rd_addr, rd_sel, note_out, note_valid, done_rand, done_save} !== 13'd0) begin
      failures++;
      $display("FAIL %s: got addr=%0d sel=%b note=%0d nv=%b dr=%b ds=%b, want all zero",
               name, rd_addr, rd_sel, note_out, note_valid, done_rand, done_save);
    end
  endtask

  // Apply each row at the falling edge, compare after the next rising edge.
  task automatic run_vectors(input string name);
    logic       e_nv;
    logic [3:0] e_note;
    for (int i = 0; i < tv.size(); i++) begin
      start_rand = tv[i].sr;
      start_save = tv[i].ss;
      end_early  = tv[i].ee;
      init       = tv[i].it;
      @(posedge clk);
      @(negedge clk);
      e_nv   = tv[i].nv && !(GAP && tv[i].lt);
      e_note = e_nv ? tv[i].note : 4'd0;
      checks++;
      if ({rd_addr, rd_sel, note_valid, note_out, done_rand, done_save} !==
          {tv[i].addr, tv[i].sel, e_nv, e_note, tv[i].dr, tv[i].ds}) begin
        failures++;
        $display("FAIL %s row %0d: got addr=%0d sel=%b nv=%b note=%0d dr=%b ds=%b, want addr=%0d sel=%b nv=%b note=%0d dr=%b ds=%b",
                 name, i, rd_addr, rd_sel, note_valid, note_out, done_rand, done_save,
                 tv[i].addr, tv[i].sel, e_nv, e_note, tv[i].dr, tv[i].ds);
      end
    end
    tv.delete();
  endtask

  initial begin
    reset_n    = 1'b0;
    init       = 1'b0;
    start_rand = 1'b0;
    start_save = 1'b0;
    end_early  = 1'b0;
    for (int b = 0; b < 2; b++) begin
      for (int a = 0; a < 32; a++) begin
        mem_note[b][a] = 4'd0;
        mem_len[b][a]  = 3'd0;
      end
    end
    mem_note[0][0] = 4'd3; mem_len[0][0] = 3'd2;
    mem_note[0][1] = 4'd5; mem_len[0][1] = 3'd1;
    mem_note[1][0] = 4'd9; mem_len[1][0] = 3'd1;

    repeat (2) @(negedge clk);
    check_zero("reset_state");
    reset_n = 1'b1;

    // Random score, then HALT with start_rand still held.
    add_note(1, 0, 0, 0, 4'd3, 2, 8);
    add_note(1, 0, 1, 0, 4'd5, 1, 4);
    add_end(1, 0, 2, 0);
    add_idle(1, 0, 0, 0);
    add_idle(1, 0, 0, 0);
    // init with start_rand held: replay from address 0, end_early in 2nd note.
    add_idle(1, 0, 0, 1);
    add_note(1, 0, 0, 0, 4'd3, 2, 8);
    add_note(1, 0, 1, 0, 4'd5, 1, 2);
    add_idle(1, 0, 1, 0);
    add_idle(0, 0, 0, 0);
    add_idle(0, 0, 0, 0);
    // init takes priority over start_save, then saved score plays.
    add_idle(0, 1, 0, 1);
    add_note(0, 1, 0, 1, 4'd9, 1, 4);
    add_end(0, 1, 1, 1);
    add_idle(0, 1, 0, 0);
    // Both start levels dropping mid-note aborts.
    add_idle(0, 0, 0, 1);
    add_note(1, 0, 0, 0, 4'd3, 2, 3);
    add_idle(0, 0, 0, 0);
    add_idle(0, 0, 0, 0);
    // end_early during LOAD aborts before any note sounds.
    add_note(1, 0, 0, 0, 4'd3, 2, 0);
    add_idle(1, 0, 1, 0);
    add_idle(0, 0, 0, 0);
    run_vectors("scores");

    // Both starts at the same edge: random memory wins.
    mem_len[0][0] = 3'd0;
    add_end(1, 1, 0, 0);
    add_idle(1, 1, 0, 0);
    add_idle(0, 0, 0, 1);
    run_vectors("both_starts");

    // Full memory, no end marker, every note one tick long.
    for (int a = 0; a < 32; a++) begin
      mem_note[0][a] = 4'((a % 15) + 1);
      mem_len[0][a]  = 3'd1;
    end
    for (int a = 0; a < 32; a++) begin
      add_note(1, 0, a, 0, 4'((a % 15) + 1), 1, 4);
    end
    add_finish(1, 0, 31, 0);
    add_idle(0, 0, 0, 1);
    run_vectors("full_memory");

    // Asynchronous reset between clock edges while a note is sounding.
    mem_len[0][0] = 3'd2;
    add_note(1, 0, 0, 0, 4'd1, 2, 2);
    run_vectors("pre_reset");
    @(posedge clk);
    #1;
    checks++;
    if (!(note_valid === 1'b1 && note_out === 4'd1)) begin
      failures++;
      $display("FAIL pre_reset_play: got nv=%b note=%0d, want nv=1 note=1", note_valid, note_out);
    end
    #1;
    reset_n = 1'b0;
    #1;
    check_zero("async_reset");
    @(negedge clk);
    start_rand = 1'b0;
    check_zero("reset_held");
    reset_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_zero("after_reset_idle");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
